// File: rtl/pipe_cla_adder.sv
// ============================================================================
// Module   : pipe_cla_adder
// Brief    : Two-stage valid/ready pipelined carry-lookahead adder with
//            group/word propagate-generate outputs for cascading.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_cla_adder #(
    parameter int WIDTH = 12,
    parameter int GROUP = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_a,
    input  logic [WIDTH-1:0] io_b,
    input  logic             io_c_in,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_sum,
    output logic             io_c_out,
    output logic             io_ovf,
    output logic             io_pg,
    output logic             io_gg
);

    localparam int NGROUPS = WIDTH / GROUP;

    // Stage A: bitwise propagate/generate plus carry-in
    logic             r_a_valid;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_g;
    logic             r_cin;

    // Stage B: registered results
    logic             r_b_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_pg;
    logic             r_gg;

    logic w_ready_a;
    logic w_ready_b;

    assign w_ready_b   = !r_b_valid || io_out_ready;
    assign w_ready_a   = !r_a_valid || w_ready_b;
    assign io_in_ready = w_ready_a;

    // Lookahead network over the stage-A registers
    logic [NGROUPS:0]   w_gc;       // carry into each group
    logic [NGROUPS:0]   w_wg;       // word generate chain with zero carry-in
    logic [NGROUPS-1:0] w_grp_pg;
    logic [NGROUPS-1:0] w_grp_gg;
    logic [WIDTH-1:0]   w_c;        // carry into each bit
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic               w_ovf;
    logic               w_pg;
    logic               w_gg;

    assign w_gc[0] = r_cin;
    assign w_wg[0] = 1'b0;

    genvar k, j;
    generate
        for (k = 0; k < NGROUPS; k++) begin : g_group
            localparam int BASE = k * GROUP;
            logic [GROUP:0] w_z;

            assign w_z[0]      = 1'b0;
            assign w_grp_pg[k] = &r_p[BASE +: GROUP];
            assign w_grp_gg[k] = w_z[GROUP];
            assign w_gc[k+1]   = w_grp_gg[k] | (w_grp_pg[k] & w_gc[k]);
            assign w_wg[k+1]   = w_grp_gg[k] | (w_grp_pg[k] & w_wg[k]);

            for (j = 0; j < GROUP; j++) begin : g_bit
                localparam int IDX = BASE + j;

                assign w_z[j+1]   = r_g[IDX] | (r_p[IDX] & w_z[j]);
                assign w_sum[IDX] = r_p[IDX] ^ w_c[IDX];

                if (j == 0) begin : g_first
                    assign w_c[IDX] = w_gc[k];
                end else begin : g_next
                    assign w_c[IDX] = r_g[IDX-1] | (r_p[IDX-1] & w_c[IDX-1]);
                end
            end
        end
    endgenerate

    assign w_cout = w_gc[NGROUPS];
    assign w_ovf  = w_c[WIDTH-1] ^ w_cout;
    assign w_pg   = &w_grp_pg;
    assign w_gg   = w_wg[NGROUPS];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_a_valid <= 1'b0;
            r_p       <= '0;
            r_g       <= '0;
            r_cin     <= 1'b0;
        end else if (w_ready_a) begin
            r_a_valid <= io_in_valid;
            if (io_in_valid) begin
                r_p   <= io_a ^ io_b;
                r_g   <= io_a & io_b;
                r_cin <= io_c_in;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_b_valid <= 1'b0;
            r_sum     <= '0;
            r_cout    <= 1'b0;
            r_ovf     <= 1'b0;
            r_pg      <= 1'b0;
            r_gg      <= 1'b0;
        end else if (w_ready_b) begin
            r_b_valid <= r_a_valid;
            if (r_a_valid) begin
                r_sum  <= w_sum;
                r_cout <= w_cout;
                r_ovf  <= w_ovf;
                r_pg   <= w_pg;
                r_gg   <= w_gg;
            end
        end
    end

    assign io_out_valid = r_b_valid;
    assign io_sum       = r_sum;
    assign io_c_out     = r_cout;
    assign io_ovf       = r_ovf;
    assign io_pg        = r_pg;
    assign io_gg        = r_gg;

endmodule

`default_nettype wire

// File: tb/tb_pipe_cla_adder.sv
// ============================================================================
// Module   : tb_pipe_cla_adder
// Brief    : Scoreboard bench for pipe_cla_adder: directed vectors, stall,
//            mid-flight reset and random traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_cla_adder;

    localparam int WIDTH = 12;
    localparam int GROUP = 3;

    logic             clock;
    logic             reset;
    logic             io_in_valid;
    logic             io_in_ready;
    logic [WIDTH-1:0] io_a;
    logic [WIDTH-1:0] io_b;
    logic             io_c_in;
    logic             io_out_valid;
    logic             io_out_ready;
    logic [WIDTH-1:0] io_sum;
    logic             io_c_out;
    logic             io_ovf;
    logic             io_pg;
    logic             io_gg;

    int checks = 0;
    int errors = 0;

    logic [WIDTH+3:0] sb_q[$];

    pipe_cla_adder #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_a         (io_a),
        .io_b         (io_b),
        .io_c_in      (io_c_in),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_sum       (io_sum),
        .io_c_out     (io_c_out),
        .io_ovf       (io_ovf),
        .io_pg        (io_pg),
        .io_gg        (io_gg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Packed as {gg, pg, ovf, c_out, sum}
    function automatic logic [WIDTH+3:0] model(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic cin);
        logic [WIDTH:0] full;
        logic [WIDTH:0] nocin;
        logic           ovf;
        full  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        nocin = {1'b0, a} + {1'b0, b};
        ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
        return {nocin[WIDTH], &(a ^ b), ovf, full[WIDTH], full[WIDTH-1:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard bookkeeping for the coming rising edge, then advance to the next falling edge.
    task automatic tick();
        logic [WIDTH+3:0] exp;
        #1;
        if (reset) begin
            sb_q.delete();
        end else begin
            if (io_out_valid && io_out_ready) begin
                checks++;
                assert (sb_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_beat observed=%h expected=none", io_sum);
                end
                if (sb_q.size() != 0) begin
                    exp = sb_q.pop_front();
                    chk("beat", 32'({io_gg, io_pg, io_ovf, io_c_out, io_sum}), 32'(exp));
                end
            end
            if (io_in_valid && io_in_ready)
                sb_q.push_back(model(io_a, io_b, io_c_in));
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic beat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
        io_in_valid = 1'b1;
        io_a        = a;
        io_b        = b;
        io_c_in     = cin;
        tick();
        io_in_valid = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        io_in_valid  = 1'b0;
        io_a         = '0;
        io_b         = '0;
        io_c_in      = 1'b0;
        io_out_ready = 1'b1;
        @(negedge clock);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_out_valid", 32'(io_out_valid), 32'd0);
        chk("rst_sum", 32'(io_sum), 32'd0);
        chk("rst_flags", 32'({io_c_out, io_ovf, io_pg, io_gg}), 32'd0);
        chk("rst_in_ready", 32'(io_in_ready), 32'd1);

        // Word wrap-around with 2-cycle latency
        beat(12'hFFF, 12'h001, 1'b0);
        chk("lat_early", 32'(io_out_valid), 32'd0);
        tick();
        chk("lat_valid", 32'(io_out_valid), 32'd1);
        chk("wrap_sum", 32'(io_sum), 32'h000);
        chk("wrap_flags", 32'({io_c_out, io_ovf, io_pg, io_gg}), 32'b1001);
        tick();

        // Full-propagate word, back to back
        beat(12'hAAA, 12'h555, 1'b1);
        beat(12'hAAA, 12'h555, 1'b0);
        chk("prop1_sum", 32'(io_sum), 32'h000);
        chk("prop1_flags", 32'({io_c_out, io_pg, io_gg}), 32'b110);
        tick();
        chk("prop0_valid", 32'(io_out_valid), 32'd1);
        chk("prop0_sum", 32'(io_sum), 32'hFFF);
        chk("prop0_flags", 32'({io_c_out, io_pg, io_gg}), 32'b010);
        tick();

        // Signed overflow
        beat(12'h7FF, 12'h001, 1'b0);
        tick();
        chk("ovf_sum", 32'(io_sum), 32'h800);
        chk("ovf_flags", 32'({io_c_out, io_ovf}), 32'b01);
        tick();

        // Back-pressure: three beats offered, sink stalled four cycles
        io_out_ready = 1'b0;
        io_in_valid  = 1'b1;
        io_a = 12'd1; io_b = 12'd2; io_c_in = 1'b0;
        tick();
        io_a = 12'd3; io_b = 12'd4;
        tick();
        io_a = 12'd5; io_b = 12'd6;
        tick();
        #1;
        chk("full_in_ready", 32'(io_in_ready), 32'd0);
        chk("stall_sum", 32'(io_sum), 32'h003);
        tick();
        chk("stall_hold", 32'({io_out_valid, io_sum}), 32'h1003);
        io_out_ready = 1'b1;
        tick();
        io_in_valid = 1'b0;
        chk("release_sum1", 32'({io_out_valid, io_sum}), 32'h1007);
        tick();
        chk("release_sum2", 32'({io_out_valid, io_sum}), 32'h100B);
        tick();
        tick();
        chk("drained", 32'(io_out_valid), 32'd0);

        // Reset with pipeline full; a beat offered during reset must be dropped
        io_out_ready = 1'b0;
        beat(12'h123, 12'h456, 1'b1);
        beat(12'h0F0, 12'h00F, 1'b0);
        io_in_valid = 1'b1;
        io_a = 12'h111; io_b = 12'h222;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        io_in_valid = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(io_out_valid), 32'd0);
        chk("mid_rst_out", 32'({io_sum, io_c_out, io_ovf, io_pg, io_gg}), 32'd0);
        chk("mid_rst_in_ready", 32'(io_in_ready), 32'd1);
        io_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("no_stale_beat", 32'(io_out_valid), 32'd0);

        // Random traffic with random back-pressure
        for (int i = 0; i < 300; i++) begin
            io_in_valid  = 1'($urandom_range(0, 3) != 0);
            io_out_ready = 1'($urandom_range(0, 2) != 0);
            io_a         = WIDTH'($urandom);
            io_b         = WIDTH'($urandom);
            io_c_in      = 1'($urandom);
            tick();
        end
        io_in_valid  = 1'b0;
        io_out_ready = 1'b1;
        for (int i = 0; i < 20 && (sb_q.size() != 0 || io_out_valid); i++) tick();
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        chk("final_idle", 32'(io_out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
